wb_reg_timeout: RTL and testbench

- Registered Wishbone classic bridge: one slave port, one master port; every request and response crosses a flop stage, cutting combinational paths between bus segments.
- Adds byte selects, a per-transaction bus timeout that converts a silent slave into an error, abort on master cycle drop, and a saturating timeout counter for status.
- Sits between an interconnect and a slow or optional peripheral (MDIO, PHY registers, etc.).

---
 rtl/wb_reg_timeout_if.sv | 27 ++
 rtl/wb_reg_timeout.sv | 174 +++++++++++++++++
 tb/tb_wb_reg_timeout.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_reg_timeout_if.sv
// Wishbone classic bus segment: request fields from master, response fields from slave.
// One instance per side of the bridge.
interface wb_reg_timeout_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_write;
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] data_read;

    modport master (
        output cyc, stb, we, sel, addr, data_write,
        input  ack, err, data_read
    );

    modport slave (
        input  cyc, stb, we, sel, addr, data_write,
        output ack, err, data_read
    );
endinterface

// File: rtl/wb_reg_timeout.sv
// Registered Wishbone classic bridge with per-transaction timeout, abort on cycle drop
// and a saturating count of timed-out transactions.
module wb_reg_timeout #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_reg_timeout_if.slave      s_bus,
    wb_reg_timeout_if.master     m_bus,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] timeout_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  m_req_q, m_req_d;
    logic                  m_we_q, m_we_d;
    logic [SEL_WIDTH-1:0]  m_sel_q, m_sel_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_data_write_q, m_data_write_d;
    logic                  s_ack_q, s_ack_d;
    logic                  s_err_q, s_err_d;
    logic [DATA_WIDTH-1:0] s_data_read_q, s_data_read_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  timeout_count_q, timeout_count_d;

    logic load_c;
    logic dec_c;
    logic expired_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            m_req_q         <= 1'b0;
            m_we_q          <= 1'b0;
            m_sel_q         <= '0;
            m_addr_q        <= '0;
            m_data_write_q  <= '0;
            s_ack_q         <= 1'b0;
            s_err_q         <= 1'b0;
            s_data_read_q   <= '0;
            timeout_q       <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            m_req_q         <= m_req_d;
            m_we_q          <= m_we_d;
            m_sel_q         <= m_sel_d;
            m_addr_q        <= m_addr_d;
            m_data_write_q  <= m_data_write_d;
            s_ack_q         <= s_ack_d;
            s_err_q         <= s_err_d;
            s_data_read_q   <= s_data_read_d;
            timeout_q       <= timeout_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // Next-state and registered-output logic; BUSY arms are in priority order
    always_comb begin
        state_d         = state_q;
        m_req_d         = m_req_q;
        m_we_d          = m_we_q;
        m_sel_d         = m_sel_q;
        m_addr_d        = m_addr_q;
        m_data_write_d  = m_data_write_q;
        s_ack_d         = 1'b0;
        s_err_d         = 1'b0;
        s_data_read_d   = s_data_read_q;
        timeout_d       = 1'b0;
        timeout_count_d = timeout_count_q;
        load_c          = 1'b0;
        dec_c           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s_bus.cyc && s_bus.stb) begin
                    m_we_d         = s_bus.we;
                    m_sel_d        = s_bus.sel;
                    m_addr_d       = s_bus.addr;
                    m_data_write_d = s_bus.data_write;
                    m_req_d        = 1'b1;
                    load_c         = 1'b1;
                    state_d        = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!s_bus.cyc) begin
                    m_req_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (m_bus.err) begin
                    s_err_d = 1'b1;
                    m_req_d = 1'b0;
                    state_d = ST_RESP;
                end else if (m_bus.ack) begin
                    s_ack_d       = 1'b1;
                    s_data_read_d = m_bus.data_read;
                    m_req_d       = 1'b0;
                    state_d       = ST_RESP;
                end else if (expired_c) begin
                    s_err_d   = 1'b1;
                    timeout_d = 1'b1;
                    if (timeout_count_q != '1) begin
                        timeout_count_d = timeout_count_q + CNT_WIDTH'(1);
                    end
                    m_req_d = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    dec_c = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // Wait-cycle down-counter; reaching zero while still busy means the slave is silent
    if (TIMEOUT != 0) begin : g_timer
        localparam int unsigned TW = $clog2(TIMEOUT + 1);

        logic [TW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (load_c) begin
                cnt_d = TW'(TIMEOUT - 1);
            end else if (dec_c && (cnt_q != '0)) begin
                cnt_d = cnt_q - TW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired_c = (cnt_q == '0);
    end else begin : g_no_timer
        assign expired_c = 1'b0;
    end

    assign m_bus.cyc        = m_req_q;
    assign m_bus.stb        = m_req_q;
    assign m_bus.we         = m_we_q;
    assign m_bus.sel        = m_sel_q;
    assign m_bus.addr       = m_addr_q;
    assign m_bus.data_write = m_data_write_q;

    assign s_bus.ack        = s_ack_q;
    assign s_bus.err        = s_err_q;
    assign s_bus.data_read  = s_data_read_q;

    assign timeout          = timeout_q;
    assign timeout_count    = timeout_count_q;

endmodule

// File: tb/tb_wb_reg_timeout.sv
// Self-checking bench for wb_reg_timeout: scoreboarded responses, request-field stability,
// timeout boundary, saturation, abort and asynchronous reset.
module tb_wb_reg_timeout;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_reg_timeout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();
    wb_reg_timeout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();

    logic          timeout;
    logic [CW-1:0] timeout_count;

    wb_reg_timeout #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_bus        (s_bus),
        .m_bus        (m_bus),
        .timeout      (timeout),
        .timeout_count(timeout_count)
    );

    typedef struct {
        logic          ack;
        logic          err;
        logic          tmo;
        logic [DW-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every s_ack/s_err/timeout cycle must match the next expected response
    always @(negedge clk) begin
        resp_t e;
        if (rst && (s_bus.ack || s_bus.err || timeout)) begin
            if (exp_q.size() == 0) begin
                check("spurious_resp", 32'({s_bus.ack, s_bus.err, timeout}), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("s_ack", 32'(s_bus.ack), 32'(e.ack));
                check("s_err", 32'(s_bus.err), 32'(e.err));
                check("timeout", 32'(timeout), 32'(e.tmo));
                if (e.ack) check("s_data_read", 32'(s_bus.data_read), 32'(e.data));
            end
        end
    end

    task automatic xfer(input logic we, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int resp_at, input logic r_ack,
                        input logic r_err, input logic [DW-1:0] rdata, input int exp_cycles,
                        input logic e_ack, input logic e_err, input logic e_tmo);
        resp_t e;
        int    n;
        e.ack = e_ack;
        e.err = e_err;
        e.tmo = e_tmo;
        e.data = rdata;
        exp_q.push_back(e);
        @(posedge clk); #1;
        s_bus.cyc = 1'b1;
        s_bus.stb = 1'b1;
        s_bus.we = we;
        s_bus.sel = sel;
        s_bus.addr = addr;
        s_bus.data_write = wdata;
        @(posedge clk); #1;
        n = 0;
        while (m_bus.stb && n < 20) begin
            check("m_cyc", 32'(m_bus.cyc), 32'(1));
            check("m_we", 32'(m_bus.we), 32'(we));
            check("m_sel", 32'(m_bus.sel), 32'(sel));
            check("m_addr", 32'(m_bus.addr), 32'(addr));
            check("m_data_write", 32'(m_bus.data_write), 32'(wdata));
            if (n == resp_at) begin
                m_bus.ack = r_ack;
                m_bus.err = r_err;
                m_bus.data_read = rdata;
            end
            n++;
            @(posedge clk); #1;
            m_bus.ack = 1'b0;
            m_bus.err = 1'b0;
        end
        check("stb_cycles", 32'(n), 32'(exp_cycles));
        check("resp_latency", 32'({s_bus.ack, s_bus.err}), 32'({e_ack, e_err}));
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        s_bus.we = 1'b0;
        s_bus.sel = '0;
        s_bus.addr = '0;
        s_bus.data_write = '0;
        m_bus.ack = 1'b0;
        m_bus.err = 1'b0;
        m_bus.data_read = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_cyc", 32'(m_bus.cyc), 32'(0));
        check("rst_m_stb", 32'(m_bus.stb), 32'(0));
        check("rst_m_addr", 32'(m_bus.addr), 32'(0));
        check("rst_s_ack", 32'(s_bus.ack), 32'(0));
        check("rst_s_err", 32'(s_bus.err), 32'(0));
        check("rst_s_data_read", 32'(s_bus.data_read), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
        check("rst_timeout_count", 32'(timeout_count), 32'(0));
        rst = 1'b1;

        // read, immediate ack
        xfer(1'b0, 2'b11, 16'h0040, 16'h0000, 0, 1'b1, 1'b0, 16'hBEEF, 1, 1'b1, 1'b0, 1'b0);
        // write after 3 wait cycles
        xfer(1'b1, 2'b01, 16'h0012, 16'hA5A5, 3, 1'b1, 1'b0, 16'h1234, 4, 1'b1, 1'b0, 1'b0);
        // silent slave
        xfer(1'b0, 2'b10, 16'h0077, 16'h0000, -1, 1'b0, 1'b0, 16'h0000, 4, 1'b0, 1'b1, 1'b1);
        check("count_after_1", 32'(timeout_count), 32'(1));
        check("data_read_held", 32'(s_bus.data_read), 32'(16'h1234));
        // ack and err together
        xfer(1'b0, 2'b11, 16'h0100, 16'h0000, 1, 1'b1, 1'b1, 16'h5555, 2, 1'b0, 1'b1, 1'b0);
        check("data_read_held_err", 32'(s_bus.data_read), 32'(16'h1234));
        // ack on the last allowed cycle beats the timeout
        xfer(1'b0, 2'b11, 16'h0200, 16'h0000, 3, 1'b1, 1'b0, 16'hC0DE, 4, 1'b1, 1'b0, 1'b0);
        check("count_unchanged", 32'(timeout_count), 32'(1));

        // abort by dropping s_cyc mid-transaction, then a late ack in IDLE
        @(posedge clk); #1;
        s_bus.cyc = 1'b1;
        s_bus.stb = 1'b1;
        s_bus.we = 1'b0;
        s_bus.addr = 16'h0300;
        @(posedge clk); #1;
        check("abort_m_stb_up", 32'(m_bus.stb), 32'(1));
        @(posedge clk); #1;
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        @(posedge clk); #1;
        check("abort_m_cyc", 32'(m_bus.cyc), 32'(0));
        check("abort_m_stb", 32'(m_bus.stb), 32'(0));
        check("abort_no_resp", 32'({s_bus.ack, s_bus.err}), 32'(0));
        m_bus.ack = 1'b1;
        m_bus.data_read = 16'hDEAD;
        @(posedge clk); #1;
        m_bus.ack = 1'b0;
        check("late_ack_m_cyc", 32'(m_bus.cyc), 32'(0));
        @(posedge clk); #1;
        check("late_ack_no_resp", 32'({s_bus.ack, s_bus.err}), 32'(0));
        check("late_ack_data", 32'(s_bus.data_read), 32'(16'hC0DE));

        // saturation of the timeout counter
        repeat (300) begin
            xfer(1'b0, 2'b01, 16'h0400, 16'h0000, -1, 1'b0, 1'b0, 16'h0000, 4, 1'b0, 1'b1, 1'b1);
        end
        check("count_saturated", 32'(timeout_count), 32'(8'hFF));

        // asynchronous reset between clock edges while busy
        @(posedge clk); #1;
        s_bus.cyc = 1'b1;
        s_bus.stb = 1'b1;
        s_bus.addr = 16'h0500;
        @(posedge clk); #1;
        check("pre_rst_m_stb", 32'(m_bus.stb), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_m_cyc", 32'(m_bus.cyc), 32'(0));
        check("async_rst_m_stb", 32'(m_bus.stb), 32'(0));
        check("async_rst_s_ack", 32'(s_bus.ack), 32'(0));
        check("async_rst_count", 32'(timeout_count), 32'(0));
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        #3;
        rst = 1'b1;
        xfer(1'b0, 2'b11, 16'h0600, 16'h0000, 0, 1'b1, 1'b0, 16'h600D, 1, 1'b1, 1'b0, 1'b0);
        check("post_rst_count", 32'(timeout_count), 32'(0));

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
